// File: rtl/fifo_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_tx_param
//  Description : Parametrised synchronous transmit FIFO for the SpaceWire TX
//                path. Buffers N-Char words between the host writer and the
//                TX encoder, with almost-full/almost-empty thresholds, sticky
//                overflow/underflow flags, synchronous flush and a selectable
//                standard or first-word-fall-through read port.
//  Revision    : 1.0  - initial release
// ============================================================================
module fifo_tx_param #(
    parameter int DWIDTH     = 9,
    parameter int AWIDTH     = 6,
    parameter int AFULL_LVL  = 56,
    parameter int AEMPTY_LVL = 4,
    parameter int FWFT       = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] data_in,
    input  logic              rd_en,
    input  logic              flush,
    input  logic              clr_err,
    output logic [DWIDTH-1:0] data_out,
    output logic              write_tx,
    output logic              f_full,
    output logic              f_empty,
    output logic              f_afull,
    output logic              f_aempty,
    output logic [AWIDTH:0]   counter,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_DEPTH_N = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] c_DEPTH   = (AWIDTH + 1)'(c_DEPTH_N);
    localparam logic [AWIDTH:0] c_AFULL   = (AWIDTH + 1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] c_AEMPTY  = (AWIDTH + 1)'(AEMPTY_LVL);
    localparam logic [AWIDTH:0] c_CNT_ONE = (AWIDTH + 1)'(1);
    localparam logic [AWIDTH-1:0] c_PTR_ONE = AWIDTH'(1);

    // Storage is deliberately left without reset so it maps onto RAM.
    logic [DWIDTH-1:0] r_mem [c_DEPTH_N];

    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_counter;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wa;
    logic              w_ra;
    logic              w_ov_set;
    logic              w_uv_set;
    logic [AWIDTH:0]   w_cnt_next;

    // Accept qualification: flush overrides both ports, and a full/empty FIFO
    // rejects the request regardless of activity on the other port.
    always_comb begin
        w_wa     = wr_en && !r_full  && !flush;
        w_ra     = rd_en && !r_empty && !flush;
        w_ov_set = wr_en &&  r_full  && !flush;
        w_uv_set = rd_en &&  r_empty && !flush;
    end

    // Next occupancy; every flag below is derived from this value so that the
    // registered flags always agree with the registered counter.
    always_comb begin
        w_cnt_next = r_counter;
        if (flush) begin
            w_cnt_next = '0;
        end else if (w_wa && !w_ra) begin
            w_cnt_next = r_counter + c_CNT_ONE;
        end else if (w_ra && !w_wa) begin
            w_cnt_next = r_counter - c_CNT_ONE;
        end
    end

    // Write port into the storage array.
    always_ff @(posedge clock) begin
        if (w_wa) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally at DEPTH because they are exactly AWIDTH wide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wa) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_ra) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Occupancy counter and status flags, all registered from the next count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_counter <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_afull   <= 1'b0;
            r_aempty  <= 1'b1;
        end else begin
            r_counter <= w_cnt_next;
            r_full    <= (w_cnt_next == c_DEPTH);
            r_empty   <= (w_cnt_next == '0);
            r_afull   <= (w_cnt_next >= c_AFULL);
            r_aempty  <= (w_cnt_next <= c_AEMPTY);
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ov_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_uv_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DWIDTH-1:0] r_data_out;
            logic              r_write_tx;

            // Registered read: the word appears one cycle after the pop,
            // flagged by a single-cycle write_tx pulse; data holds otherwise.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_data_out <= '0;
                    r_write_tx <= 1'b0;
                end else begin
                    r_write_tx <= w_ra;
                    if (w_ra) begin
                        r_data_out <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign data_out = r_data_out;
            assign write_tx = r_write_tx;
        end else begin : g_fwft_read
            // Head of queue is presented directly; it is forced to zero while
            // empty so the port reads as zero after reset or flush instead of
            // exposing stale or uninitialised storage.
            assign data_out = r_empty ? '0 : r_mem[r_rd_ptr];
            assign write_tx = !r_empty;
        end
    endgenerate

    assign f_full    = r_full;
    assign f_empty   = r_empty;
    assign f_afull   = r_afull;
    assign f_aempty  = r_aempty;
    assign counter   = r_counter;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
